display_scan_ctrl: RTL and testbench

//  Sequences the six-digit multiplexed 7-seg panel behind the display decoders.

---
 rtl/display_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//   Drives a six-digit multiplexed 7-segment panel. Picks the TIME, DATE or
//   ALARM segment set, scans it one digit per slot (order 5,4,3,2,1,0) and puts
//   one blank cycle between digits. The field being edited blinks.
//
//   Optional feature macro: AUTO_RETURN_EN
//     When defined, the display returns to TIME after RETURN_TICKS idle clocks
//     away from TIME with no edit and no MODE_STEP.
//
// Ports
//   CLK           in   1   system clock, rising edge
//   RESET         in   1   synchronous, active-high reset
//   IN_TIME_SEG   in  48   {H10,H1,M10,M1,S10,S1}, 8b codes, H10 in [47:40]
//   IN_DATE_SEG   in  48   {Y10,Y1,MT10,MT1,D10,D1}
//   IN_ALARM_SEG  in  48   {AH10,AH1,AM10,AM1,AS10,AS1}
//   MODE_STEP     in   1   one-cycle pulse: advance display mode
//   EDIT_ACTIVE   in   1   a field is being edited (locks mode, enables blink)
//   EDIT_FIELD    in   2   0=digits 5:4, 1=digits 3:2, 2=digits 1:0, 3=none
//   OUT_MODE      out  2   0=TIME, 1=DATE, 2=ALARM
//   OUT_SEG       out  8   segment code of the scanned digit, 8'h00 = blank
//   OUT_COM       out  6   active-low one-hot digit enables, bit5 = leftmost
//   OUT_BLINK     out  1   blink phase (1 = blank phase)
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_DIV    = 500000,
  parameter int unsigned RETURN_TICKS = 5000000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [47:0] IN_TIME_SEG,
  input  logic [47:0] IN_DATE_SEG,
  input  logic [47:0] IN_ALARM_SEG,
  input  logic        MODE_STEP,
  input  logic        EDIT_ACTIVE,
  input  logic [1:0]  EDIT_FIELD,
  output logic [1:0]  OUT_MODE,
  output logic [7:0]  OUT_SEG,
  output logic [5:0]  OUT_COM,
  output logic        OUT_BLINK
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  // BLANK: waiting for the first tick after reset.
  // DRIVE: single cycle that enables the digit loaded on the tick.
  // HOLD : digit stays enabled until the next tick reloads.
  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    M_TIME  = 2'd0,
    M_DATE  = 2'd1,
    M_ALARM = 2'd2
  } mode_e;

  scan_state_e       r_state;
  scan_state_e       w_state_nxt;
  mode_e             r_mode;
  mode_e             w_mode_nxt;
  logic [SCAN_W-1:0] r_scan;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [2:0]        r_idx;
  logic              w_tick;
  logic              w_return;
  logic              w_in_field;
  logic              w_blank;
  logic [47:0]       w_src;
  logic [7:0]        w_code;
  logic [5:0]        w_com_nxt;
  logic [7:0]        w_seg_nxt;
  logic [2:0]        w_idx_nxt;

  assign OUT_MODE = r_mode;

  // ---------------------------------------------------------------------------
  // Slot timer
  // ---------------------------------------------------------------------------
  assign w_tick = (r_scan == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_scan <= '0;
    end else if (w_tick) begin
      r_scan <= '0;
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase: held in the visible phase whenever no edit is active
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET || !EDIT_ACTIVE) begin
      r_blink_cnt <= '0;
      OUT_BLINK   <= 1'b0;
    end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
      OUT_BLINK   <= ~OUT_BLINK;
    end else begin
      r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Idle auto-return to TIME
  // ---------------------------------------------------------------------------
`ifdef AUTO_RETURN_EN
  localparam int unsigned IDLE_W = (RETURN_TICKS > 2) ? $clog2(RETURN_TICKS) : 1;

  logic [IDLE_W-1:0] r_idle;
  logic              w_idle_run;

  assign w_idle_run = (r_mode != M_TIME) && !EDIT_ACTIVE && !MODE_STEP;
  assign w_return   = w_idle_run && (r_idle == IDLE_W'(RETURN_TICKS - 1));

  always_ff @(posedge CLK) begin
    if (RESET || !w_idle_run || w_return) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IDLE_W'(1);
    end
  end
`else
  logic w_unused_return;

  assign w_return        = 1'b0;
  assign w_unused_return = (RETURN_TICKS != 0);
`endif

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mode <= M_TIME;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (MODE_STEP && !EDIT_ACTIVE) begin
      case (r_mode)
        M_TIME:  w_mode_nxt = M_DATE;
        M_DATE:  w_mode_nxt = M_ALARM;
        default: w_mode_nxt = M_TIME;
      endcase
    end else if (w_return) begin
      w_mode_nxt = M_TIME;
    end
  end

  // ---------------------------------------------------------------------------
  // Segment source selection for the digit about to be loaded
  // ---------------------------------------------------------------------------
  always_comb begin
    case (r_mode)
      M_DATE:  w_src = IN_DATE_SEG;
      M_ALARM: w_src = IN_ALARM_SEG;
      default: w_src = IN_TIME_SEG;
    endcase
  end

  always_comb begin
    case (r_idx)
      3'd5:    w_code = w_src[47:40];
      3'd4:    w_code = w_src[39:32];
      3'd3:    w_code = w_src[31:24];
      3'd2:    w_code = w_src[23:16];
      3'd1:    w_code = w_src[15:8];
      default: w_code = w_src[7:0];
    endcase
  end

  always_comb begin
    case (EDIT_FIELD)
      2'd0:    w_in_field = (r_idx == 3'd5) || (r_idx == 3'd4);
      2'd1:    w_in_field = (r_idx == 3'd3) || (r_idx == 3'd2);
      2'd2:    w_in_field = (r_idx == 3'd1) || (r_idx == 3'd0);
      default: w_in_field = 1'b0;
    endcase
  end

  assign w_blank = EDIT_ACTIVE && OUT_BLINK && w_in_field;

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (w_tick) w_state_nxt = S_DRIVE;
      S_DRIVE: w_state_nxt = S_HOLD;
      S_HOLD:  if (w_tick) w_state_nxt = S_DRIVE;
      default: w_state_nxt = S_BLANK;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: output register next values
  // The tick reload out of HOLD is the same load as out of BLANK, so a digit
  // occupies exactly one slot: one blank cycle, then enabled until the tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_com_nxt = OUT_COM;
    w_seg_nxt = OUT_SEG;
    w_idx_nxt = r_idx;
    case (r_state)
      S_BLANK, S_HOLD: begin
        if (w_tick) begin
          w_com_nxt = '1;
          w_seg_nxt = w_blank ? 8'h00 : w_code;
        end
      end
      S_DRIVE: begin
        w_com_nxt = ~(6'b00_0001 << r_idx);
        w_idx_nxt = (r_idx == 3'd0) ? 3'd5 : (r_idx - 3'd1);
      end
      default: begin
        w_com_nxt = '1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_COM <= '1;
      OUT_SEG <= '0;
      r_idx   <= 3'd5;
    end else begin
      OUT_COM <= w_com_nxt;
      OUT_SEG <= w_seg_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//   Randomized self-checking bench for display_scan_ctrl with SCAN_DIV=4,
//   BLINK_DIV=16, RETURN_TICKS=40. The reference model works from elapsed
//   time since reset: digit slot number, edit duration and idle duration.
//   Define AUTO_RETURN_EN for both RTL and bench to check the auto-return build.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int unsigned S = 4;
  localparam int unsigned B = 16;
  localparam int unsigned R = 40;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [47:0] IN_TIME_SEG;
  logic [47:0] IN_DATE_SEG;
  logic [47:0] IN_ALARM_SEG;
  logic        MODE_STEP;
  logic        EDIT_ACTIVE;
  logic [1:0]  EDIT_FIELD;
  logic [1:0]  OUT_MODE;
  logic [7:0]  OUT_SEG;
  logic [5:0]  OUT_COM;
  logic        OUT_BLINK;

  display_scan_ctrl #(
    .SCAN_DIV    (S),
    .BLINK_DIV   (B),
    .RETURN_TICKS(R)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN_TIME_SEG (IN_TIME_SEG),
    .IN_DATE_SEG (IN_DATE_SEG),
    .IN_ALARM_SEG(IN_ALARM_SEG),
    .MODE_STEP   (MODE_STEP),
    .EDIT_ACTIVE (EDIT_ACTIVE),
    .EDIT_FIELD  (EDIT_FIELD),
    .OUT_MODE    (OUT_MODE),
    .OUT_SEG     (OUT_SEG),
    .OUT_COM     (OUT_COM),
    .OUT_BLINK   (OUT_BLINK)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_t;     // clocks since reset release
  int unsigned m_n;     // consecutive clocks with edit active
  int unsigned m_mode;  // 0 TIME, 1 DATE, 2 ALARM
  int unsigned m_idle;  // consecutive idle clocks away from TIME
  logic [7:0]  m_seg;

  logic [16:0] got;
  logic [16:0] exp;

  function automatic logic [7:0] code_of(input int unsigned mode, input int unsigned d);
    logic [47:0] v;
    v = (mode == 1) ? IN_DATE_SEG : (mode == 2) ? IN_ALARM_SEG : IN_TIME_SEG;
    return v[d*8 +: 8];
  endfunction

  function automatic int unsigned digit_of_slot(input int unsigned k);
    return 5 - ((k - 1) % 6);
  endfunction

  function automatic logic [5:0] exp_com();
    logic [5:0] one;
    if (m_t <= S || (m_t % S) == 0) return 6'h3F;
    one = 6'd1 << digit_of_slot(m_t / S);
    return ~one;
  endfunction

  function automatic logic [16:0] exp_vec();
    logic blink;
    blink = ((m_n / B) % 2) == 1;
    return {2'(m_mode), m_seg, exp_com(), blink};
  endfunction

  function automatic logic [47:0] rnd_segs();
    logic [47:0] v;
    for (int i = 0; i < 6; i++) v[i*8 +: 8] = 8'($urandom_range(1, 255));
    return v;
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic cyc();
    int unsigned d;
    logic        blank;
    @(posedge CLK);
    if (RESET) begin
      m_t = 0; m_n = 0; m_mode = 0; m_idle = 0; m_seg = 8'h00;
    end else begin
      if (((m_t + 1) % S) == 0) begin
        d = digit_of_slot((m_t + 1) / S);
        blank = EDIT_ACTIVE && (((m_n / B) % 2) == 1) && (EDIT_FIELD != 2'd3) &&
                ((d / 2) == (2 - int'(EDIT_FIELD)));
        m_seg = blank ? 8'h00 : code_of(m_mode, d);
      end
      if (MODE_STEP && !EDIT_ACTIVE) begin
        m_mode = (m_mode + 1) % 3;
        m_idle = 0;
      end
`ifdef AUTO_RETURN_EN
      else if (m_mode != 0 && !EDIT_ACTIVE && !MODE_STEP) begin
        m_idle++;
        if (m_idle == R) begin
          m_mode = 0;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
`endif
      m_n = EDIT_ACTIVE ? m_n + 1 : 0;
      m_t++;
    end
    #1;
    got = {OUT_MODE, OUT_SEG, OUT_COM, OUT_BLINK};
    exp = exp_vec();
  endtask

  task automatic pulse_step();
    MODE_STEP = 1'b1;
    cyc();
    MODE_STEP = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1; MODE_STEP = 1'b0; EDIT_ACTIVE = 1'b0; EDIT_FIELD = 2'd3;
    IN_TIME_SEG = rnd_segs(); IN_DATE_SEG = rnd_segs(); IN_ALARM_SEG = rnd_segs();
    cyc(); cyc();
    checks++;
    if (got !== {2'd0, 8'h00, 6'h3F, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got mode/seg/com/blink=%h want %h", got, {2'd0, 8'h00, 6'h3F, 1'b0});
    end
    RESET = 1'b0;
  endtask

  task automatic test_scan_order();
    RESET = 1'b1; cyc(); RESET = 1'b0;
    IN_TIME_SEG = 48'h010203040506;
    for (int i = 0; i < 60; i++) begin
      cyc();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL scan_model t=%0d got %h want %h", m_t, got, exp);
      end
      if (m_t == 4 || m_t == 5 || m_t == 9 || m_t == 25 || m_t == 29) begin
        checks++;
        if ((m_t == 4  && {OUT_SEG, OUT_COM} !== {8'h01, 6'h3F}) ||
            (m_t == 5  && {OUT_SEG, OUT_COM} !== {8'h01, 6'h1F}) ||
            (m_t == 9  && {OUT_SEG, OUT_COM} !== {8'h02, 6'h2F}) ||
            (m_t == 25 && {OUT_SEG, OUT_COM} !== {8'h06, 6'h3E}) ||
            (m_t == 29 && {OUT_SEG, OUT_COM} !== {8'h01, 6'h1F})) begin
          failures++;
          $display("FAIL scan_fixed t=%0d got seg=%h com=%h", m_t, OUT_SEG, OUT_COM);
        end
      end
    end
  endtask

  task automatic test_mode_cycling();
    IN_TIME_SEG = rnd_segs(); IN_DATE_SEG = rnd_segs(); IN_ALARM_SEG = rnd_segs();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < int'($urandom_range(5, 15)); i++) begin
        cyc();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL mode_model t=%0d got %h want %h", m_t, got, exp);
        end
      end
      pulse_step();
      checks++;
      if (OUT_MODE !== 2'((p + 1) % 3)) begin
        failures++;
        $display("FAIL mode_step got %0d want %0d", OUT_MODE, (p + 1) % 3);
      end
      for (int i = 0; i < 30; i++) begin
        cyc();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL mode_follow t=%0d got %h want %h", m_t, got, exp);
        end
      end
    end
  endtask

  task automatic test_blink();
    int blanked;
    blanked = 0;
    IN_TIME_SEG = rnd_segs(); IN_DATE_SEG = rnd_segs(); IN_ALARM_SEG = rnd_segs();
    EDIT_ACTIVE = 1'b1; EDIT_FIELD = 2'd1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL blink_field1 t=%0d got %h want %h", m_t, got, exp);
      end
      if ((OUT_COM == 6'h37 || OUT_COM == 6'h3B) && OUT_SEG == 8'h00) blanked++;
    end
    checks++;
    if (blanked == 0) begin
      failures++;
      $display("FAIL blink_seen got blanked_cycles=%0d want >0", blanked);
    end
    EDIT_FIELD = 2'd3;
    for (int i = 0; i < 100; i++) begin
      cyc();
      checks++;
      if (got !== exp || (OUT_COM != 6'h3F && OUT_SEG == 8'h00 && m_t > 2 * S)) begin
        failures++;
        $display("FAIL blink_none t=%0d got %h want %h", m_t, got, exp);
      end
    end
    EDIT_ACTIVE = 1'b0;
    cyc();
  endtask

  task automatic test_mode_lock();
    int unsigned old_mode;
    int unsigned d;
    logic        found;
    old_mode = m_mode;
    EDIT_ACTIVE = 1'b1;
    pulse_step();
    cyc();
    checks++;
    if (OUT_MODE !== 2'(old_mode)) begin
      failures++;
      $display("FAIL mode_lock got %0d want %0d", OUT_MODE, old_mode);
    end
    EDIT_ACTIVE = 1'b0;
    cyc();
    found = 1'b0;
    for (int i = 0; i < int'(2 * S) && !found; i++) begin
      if (((m_t + 1) % S) == 0) found = 1'b1;
      else cyc();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL tick_wait got no tick within %0d cycles", 2 * S);
    end
    old_mode = m_mode;
    pulse_step();
    d = digit_of_slot(m_t / S);
    checks++;
    if (OUT_SEG !== code_of(old_mode, d) || OUT_MODE !== 2'((old_mode + 1) % 3)) begin
      failures++;
      $display("FAIL tick_old_mode got seg=%h mode=%0d want seg=%h mode=%0d",
               OUT_SEG, OUT_MODE, code_of(old_mode, d), (old_mode + 1) % 3);
    end
    for (int i = 0; i < int'(S); i++) cyc();
    d = digit_of_slot(m_t / S);
    checks++;
    if (OUT_SEG !== code_of((old_mode + 1) % 3, d)) begin
      failures++;
      $display("FAIL tick_new_mode got seg=%h want %h", OUT_SEG, code_of((old_mode + 1) % 3, d));
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    if (m_mode == 0) pulse_step();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc();
      if (OUT_COM == 6'h3B) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL digit2_wait got no digit 2 enable within 200 cycles");
    end
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    checks++;
    if ({OUT_COM, OUT_SEG, OUT_MODE} !== {6'h3F, 8'h00, 2'd0}) begin
      failures++;
      $display("FAIL reset_mid got com=%h seg=%h mode=%0d want 3f 00 0", OUT_COM, OUT_SEG, OUT_MODE);
    end
    for (int i = 0; i < int'(S + 1); i++) begin
      cyc();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_restart t=%0d got %h want %h", m_t, got, exp);
      end
    end
    checks++;
    if (OUT_COM !== 6'h1F) begin
      failures++;
      $display("FAIL reset_first_digit got com=%h want 1f", OUT_COM);
    end
  endtask

  task automatic test_auto_return();
    logic [1:0] want;
    EDIT_ACTIVE = 1'b0;
    for (int i = 0; i < 3 && m_mode != 1; i++) pulse_step();
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL idle_model t=%0d got %h want %h", m_t, got, exp);
      end
    end
    checks++;
    if (OUT_MODE !== 2'd1) begin
      failures++;
      $display("FAIL idle_early got mode=%0d want 1", OUT_MODE);
    end
    for (int i = 0; i < 20; i++) cyc();
`ifdef AUTO_RETURN_EN
    want = 2'd0;
`else
    want = 2'd1;
`endif
    checks++;
    if (OUT_MODE !== want) begin
      failures++;
      $display("FAIL idle_return got mode=%0d want %0d", OUT_MODE, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      RESET       = ($urandom_range(0, 199) == 0);
      MODE_STEP   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 29) == 0) EDIT_ACTIVE = ~EDIT_ACTIVE;
      if ($urandom_range(0, 19) == 0) EDIT_FIELD = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) IN_TIME_SEG  = rnd_segs();
      if ($urandom_range(0, 7) == 0) IN_DATE_SEG  = rnd_segs();
      if ($urandom_range(0, 7) == 0) IN_ALARM_SEG = rnd_segs();
      cyc();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random t=%0d got %h want %h", m_t, got, exp);
      end
    end
    RESET = 1'b0; MODE_STEP = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_mode_cycling();
    test_blink();
    test_mode_lock();
    test_reset_mid();
    test_auto_return();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
